// File: rtl/pq_pkg.sv
// ============================================================================
// Package : pq_pkg
// Brief   : Shared widths, entry type and sequencer enums for the heap queue.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pq_pkg;

  localparam int PQ_CAPACITY = 8;
  localparam int KEY_WIDTH   = 8;
  localparam int VAL_WIDTH   = 8;
  localparam int CNT_W       = $clog2(PQ_CAPACITY + 1);

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  localparam kv_t KV0 = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_HOLD = 2'd2,
    S_WAIT = 2'd3
  } pqc_state_t;

  typedef enum logic [1:0] {
    OP_ENQ = 2'd0,
    OP_DEQ = 2'd1,
    OP_REP = 2'd2
  } pqc_op_t;

endpackage

`default_nettype wire

// File: rtl/pq_if.sv
// ============================================================================
// Interface : pq_if
// Brief     : Command/status bundle between the sequencer and the heap queue.
// Rev       : 1.0  initial release
// ============================================================================
`default_nettype none

interface pq_if;
  import pq_pkg::*;

  logic enq;
  logic deq;
  kv_t  kvi;
  kv_t  kvo;
  logic full;
  logic empty;
  logic busy;

  modport drv  (output enq, deq, kvi, input  kvo, full, empty, busy);
  modport heap (input  enq, deq, kvi, output kvo, full, empty, busy);
endinterface

`default_nettype wire

// File: rtl/kv_fifo.sv
// ============================================================================
// Module : kv_fifo
// Brief  : Show-ahead synchronous FIFO of kv_t entries with wrap-bit flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module kv_fifo
  import pq_pkg::*;
#(
  parameter int D = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  kv_t  din,
  input  logic pop,
  output kv_t  head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(D);

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  kv_t           r_mem [D];
  logic          w_push;
  logic          w_pop;

  // Flags come straight from the pointer registers, so a same-cycle pop
  // never makes room for a same-cycle push.
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/pq_ctrl.sv
// ============================================================================
// Module : pq_ctrl
// Brief  : Sequencer turning insert/pop requests into heap enq/deq strobes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pq_ctrl
  import pq_pkg::*;
#(
  parameter int INS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ins_valid,
  output logic             ins_ready,
  input  kv_t              ins_kv,
  input  logic             pop_req,
  output logic             pop_gnt,
  output logic             pop_valid,
  output kv_t              pop_kv,
  output logic             pop_err,
  output logic [CNT_W-1:0] count,
  pq_if.drv                pq
);

  pqc_state_t       r_state;
  pqc_state_t       w_state_nxt;
  pqc_op_t          r_op;
  pqc_op_t          w_op_nxt;
  kv_t              r_pop_kv;
  logic             r_pop_valid;
  logic [CNT_W-1:0] r_count;
  kv_t              w_fifo_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_cmd;
  logic             w_is_enq;
  logic             w_is_deq;

  kv_fifo #(.D(INS_DEPTH)) u_ins_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ins_valid),
    .din   (ins_kv),
    .pop   (w_cmd && w_is_enq),
    .head  (w_fifo_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  assign w_cmd    = (r_state == S_CMD);
  assign w_is_enq = (r_op == OP_ENQ) || (r_op == OP_REP);
  assign w_is_deq = (r_op == OP_DEQ) || (r_op == OP_REP);

  assign pq.enq    = w_cmd && w_is_enq;
  assign pq.deq    = w_cmd && w_is_deq;
  assign pq.kvi    = w_fifo_head;
  assign ins_ready = !w_fifo_full;
  assign pop_gnt   = w_cmd && w_is_deq;
  assign pop_valid = r_pop_valid;
  assign pop_kv    = r_pop_kv;
  assign count     = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_ENQ;
      r_pop_kv    <= KV0;
      r_pop_valid <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_pop_valid <= w_cmd && w_is_deq;
      if (w_cmd && w_is_deq) r_pop_kv <= pq.kvo;
      if (w_cmd) begin
        case (r_op)
          OP_ENQ:  r_count <= r_count + 1'b1;
          OP_DEQ:  r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    pop_err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // An empty heap with a pending insert falls to the enq branch; the
        // pop stays pending and is served on the following pass.
        if (!pq.busy) begin
          if (pop_req && !pq.empty && !w_fifo_empty) begin
            w_op_nxt    = OP_REP;
            w_state_nxt = S_CMD;
          end else if (pop_req && !pq.empty) begin
            w_op_nxt    = OP_DEQ;
            w_state_nxt = S_CMD;
          end else if (!w_fifo_empty && !pq.full) begin
            w_op_nxt    = OP_ENQ;
            w_state_nxt = S_CMD;
          end else if (pop_req && pq.empty && w_fifo_empty) begin
            pop_err     = 1'b1;
          end
        end
      end
      S_CMD:   w_state_nxt = S_HOLD;
      S_HOLD:  w_state_nxt = S_WAIT;
      S_WAIT:  if (!pq.busy) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_pq_ctrl.sv
// ============================================================================
// Module : tb_pq_ctrl
// Brief  : Self-checking bench for pq_ctrl with a behavioural heap queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pq_ctrl;
  import pq_pkg::*;

  localparam int INS_DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ins_valid = 1'b0;
  logic             pop_req = 1'b0;
  kv_t              ins_kv = '0;
  logic             ins_ready, pop_gnt, pop_valid, pop_err;
  kv_t              pop_kv;
  logic [CNT_W-1:0] count;

  int errors = 0;
  int checks = 0;

  pq_if pq_bus ();

  pq_ctrl #(.INS_DEPTH(INS_DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .ins_kv    (ins_kv),
    .pop_req   (pop_req),
    .pop_gnt   (pop_gnt),
    .pop_valid (pop_valid),
    .pop_kv    (pop_kv),
    .pop_err   (pop_err),
    .count     (count),
    .pq        (pq_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Behavioural heap: an unordered queue whose root is its minimum key.
  kv_t  heap_q[$];
  int   sift_len = 2;
  int   bcnt = 0;
  logic st_enq = 1'b0, st_deq = 1'b0;
  kv_t  st_kvi = '0;

  function automatic int min_idx();
    int m = 0;
    for (int i = 1; i < heap_q.size(); i++)
      if (heap_q[i].key < heap_q[m].key) m = i;
    return m;
  endfunction

  always @(negedge clk) begin
    st_enq <= pq_bus.enq;
    st_deq <= pq_bus.deq;
    st_kvi <= pq_bus.kvi;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      heap_q.delete();
      bcnt         <= 0;
      pq_bus.busy  <= 1'b0;
      pq_bus.full  <= 1'b0;
      pq_bus.empty <= 1'b1;
      pq_bus.kvo   <= '0;
    end else begin
      if (st_deq && heap_q.size() > 0) heap_q.delete(min_idx());
      if (st_enq && heap_q.size() < PQ_CAPACITY) heap_q.push_back(st_kvi);
      if (st_enq || st_deq) begin
        bcnt        <= sift_len;
        pq_bus.busy <= (sift_len != 0);
      end else begin
        bcnt        <= (bcnt > 0) ? bcnt - 1 : 0;
        pq_bus.busy <= (bcnt > 1);
      end
      pq_bus.empty <= (heap_q.size() == 0);
      pq_bus.full  <= (heap_q.size() >= PQ_CAPACITY);
      pq_bus.kvo   <= (heap_q.size() > 0) ? heap_q[min_idx()] : '0;
    end
  end

  // Event monitor
  int   n_enq = 0, n_deq = 0, n_rep = 0, n_gnt = 0, n_val = 0, n_err = 0;
  int   n_gap = 0, n_viol = 0;
  logic prev_gnt = 1'b0;
  kv_t  popped_q[$];

  always @(negedge clk) begin
    if (rst) begin
      if (pq_bus.enq && pq_bus.deq) n_rep <= n_rep + 1;
      else if (pq_bus.enq)          n_enq <= n_enq + 1;
      else if (pq_bus.deq)          n_deq <= n_deq + 1;
      if ((pq_bus.enq || pq_bus.deq) && pq_bus.busy) n_viol <= n_viol + 1;
      if (pq_bus.enq && !pq_bus.deq && pq_bus.full)  n_viol <= n_viol + 1;
      if (pop_gnt) n_gnt <= n_gnt + 1;
      if (pop_err) n_err <= n_err + 1;
      if (pop_valid) begin
        n_val <= n_val + 1;
        popped_q.push_back(pop_kv);
      end
      if (pop_valid !== prev_gnt) n_gap <= n_gap + 1;
    end
    prev_gnt <= pop_gnt && rst;
  end

  function automatic kv_t mk(input int k);
    kv_t r;
    r.key = KEY_WIDTH'(k);
    r.val = VAL_WIDTH'(k * 3 + 1);
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; ins_valid = 1'b0; pop_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cyc(1);
    popped_q.delete();
  endtask

  task automatic push_kv(input kv_t kv, output bit ok);
    ins_valid = 1'b1; ins_kv = kv; ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk); ok = ins_ready;
      @(posedge clk); #1;
    end
    ins_valid = 1'b0;
  endtask

  task automatic do_pop(output bit gnt, output bit err);
    pop_req = 1'b1; gnt = 1'b0; err = 1'b0;
    for (int i = 0; i < 500 && !gnt && !err; i++) begin
      @(negedge clk);
      if (pop_gnt) gnt = 1'b1;
      if (pop_err) err = 1'b1;
      @(posedge clk); #1;
    end
    pop_req = 1'b0;
    cyc(1);
  endtask

  task automatic wait_count(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk); ok = (count == CNT_W'(n)) && !pq_bus.busy;
    end
    cyc(2);
  endtask

  task automatic wait_enq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); ok = pq_bus.enq;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ins_ready !== 1'b1) begin errors++; $display("FAIL rst_ins_ready: got %b want 1", ins_ready); end
    checks++; if (pop_gnt !== 1'b0) begin errors++; $display("FAIL rst_pop_gnt: got %b want 0", pop_gnt); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL rst_pop_valid: got %b want 0", pop_valid); end
    checks++; if (pop_err !== 1'b0) begin errors++; $display("FAIL rst_pop_err: got %b want 0", pop_err); end
    checks++; if (pop_kv !== kv_t'(0)) begin errors++; $display("FAIL rst_pop_kv: got %h want 0", pop_kv); end
    checks++; if (count !== '0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
    checks++; if ({pq_bus.enq, pq_bus.deq} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b want 00", {pq_bus.enq, pq_bus.deq}); end
    do_reset();
  endtask

  task automatic test_insert_basic();
    int e0 = n_enq, g0 = n_gnt;
    bit ok, all_ok = 1'b1;
    int keys[3] = '{5, 3, 9};
    sift_len = 3;
    foreach (keys[i]) begin
      push_kv(mk(keys[i]), ok);
      all_ok &= ok;
      cyc(20);
    end
    checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL ins_accept: got %b want 1", all_ok); end
    checks++; if (n_enq - e0 !== 3) begin errors++; $display("FAIL ins_enq_strobes: got %0d want 3", n_enq - e0); end
    checks++; if (count !== CNT_W'(3)) begin errors++; $display("FAIL ins_count: got %0d want 3", count); end
    checks++; if (n_gnt - g0 !== 0) begin errors++; $display("FAIL ins_no_gnt: got %0d want 0", n_gnt - g0); end
  endtask

  task automatic test_pop_order();
    int  v0 = n_val, gp0 = n_gap;
    bit  g, e, all_g = 1'b1;
    int  exp_keys[3] = '{3, 5, 9};
    popped_q.delete();
    for (int i = 0; i < 3; i++) begin
      do_pop(g, e);
      all_g &= g;
    end
    cyc(10);
    checks++; if (all_g !== 1'b1) begin errors++; $display("FAIL pop_grants: got %b want 1", all_g); end
    checks++; if (n_val - v0 !== 3) begin errors++; $display("FAIL pop_valid_cnt: got %0d want 3", n_val - v0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= popped_q.size() || popped_q[i] !== mk(exp_keys[i])) begin
        errors++;
        $display("FAIL pop_order[%0d]: got %h want %h", i,
                 (i < popped_q.size()) ? popped_q[i] : kv_t'(0), mk(exp_keys[i]));
      end
    end
    checks++; if (n_gap - gp0 !== 0) begin errors++; $display("FAIL pop_valid_latency: got %0d misaligned want 0", n_gap - gp0); end
    checks++; if (count !== '0) begin errors++; $display("FAIL pop_count: got %0d want 0", count); end
  endtask

  task automatic test_pop_empty();
    int r0 = n_err, s0 = n_enq + n_deq + n_rep;
    bit g, e;
    cyc(10);
    do_pop(g, e);
    cyc(5);
    checks++; if (n_err - r0 !== 1) begin errors++; $display("FAIL empty_err_pulses: got %0d want 1", n_err - r0); end
    checks++; if (g !== 1'b0) begin errors++; $display("FAIL empty_no_gnt: got %b want 0", g); end
    checks++; if (n_enq + n_deq + n_rep - s0 !== 0) begin errors++; $display("FAIL empty_no_strobe: got %0d want 0", n_enq + n_deq + n_rep - s0); end
    checks++; if (count !== '0) begin errors++; $display("FAIL empty_count: got %0d want 0", count); end
  endtask

  task automatic test_replace();
    bit ok, g, e;
    int rp0, e0, d0;
    do_reset();
    sift_len = 2;
    push_kv(mk(2), ok);
    push_kv(mk(7), ok);
    wait_count(2, ok);
    rp0 = n_rep; e0 = n_enq; d0 = n_deq;
    ins_valid = 1'b1; ins_kv = mk(1);
    @(posedge clk); #1;
    ins_valid = 1'b0;
    do_pop(g, e);
    cyc(8);
    checks++; if (n_rep - rp0 !== 1 || n_enq - e0 !== 0 || n_deq - d0 !== 0) begin
      errors++; $display("FAIL rep_strobe: got rep=%0d enq=%0d deq=%0d want 1/0/0", n_rep - rp0, n_enq - e0, n_deq - d0); end
    checks++; if (popped_q.size() < 1 || popped_q[0] !== mk(2)) begin
      errors++; $display("FAIL rep_pop_kv: got %h want %h", (popped_q.size() > 0) ? popped_q[0] : kv_t'(0), mk(2)); end
    checks++; if (count !== CNT_W'(2)) begin errors++; $display("FAIL rep_count: got %0d want 2", count); end
    do_pop(g, e);
    cyc(8);
    checks++; if (popped_q.size() < 2 || popped_q[1] !== mk(1)) begin
      errors++; $display("FAIL rep_next_pop: got %h want %h", (popped_q.size() > 1) ? popped_q[1] : kv_t'(0), mk(1)); end
    checks++; if (count !== CNT_W'(1)) begin errors++; $display("FAIL rep_count_after: got %0d want 1", count); end
  endtask

  task automatic test_burst();
    bit ok, all_rdy = 1'b1, rdy5, acc;
    int e0;
    do_reset();
    sift_len = 40;
    push_kv(mk(50), ok);
    wait_enq(ok);
    e0 = n_enq;
    for (int i = 0; i < 4; i++) begin
      ins_valid = 1'b1; ins_kv = mk(60 + i);
      @(negedge clk); all_rdy &= ins_ready;
      @(posedge clk); #1;
    end
    ins_kv = mk(70);
    @(negedge clk); rdy5 = ins_ready;
    checks++; if (all_rdy !== 1'b1) begin errors++; $display("FAIL burst_ready: got %b want 1", all_rdy); end
    checks++; if (rdy5 !== 1'b0) begin errors++; $display("FAIL burst_5th_ready: got %b want 0", rdy5); end
    acc = 1'b0;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk); acc = ins_ready;
      if (acc) begin
        checks++; if (n_enq - e0 !== 1) begin errors++; $display("FAIL burst_drain_enq: got %0d want 1", n_enq - e0); end
      end
      @(posedge clk); #1;
    end
    ins_valid = 1'b0;
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL burst_5th_accept: got %b want 1", acc); end
    sift_len = 2;
    wait_count(6, ok);
    checks++; if (count !== CNT_W'(6)) begin errors++; $display("FAIL burst_count: got %0d want 6", count); end
  endtask

  task automatic test_full();
    bit ok, g, e;
    int e0, rp0;
    do_reset();
    sift_len = 1;
    for (int i = 0; i < PQ_CAPACITY; i++) push_kv(mk(10 + i), ok);
    wait_count(PQ_CAPACITY, ok);
    push_kv(mk(4), ok);
    e0 = n_enq; rp0 = n_rep;
    cyc(20);
    checks++; if (n_enq - e0 !== 0) begin errors++; $display("FAIL full_no_enq: got %0d want 0", n_enq - e0); end
    checks++; if (count !== CNT_W'(PQ_CAPACITY)) begin errors++; $display("FAIL full_count: got %0d want %0d", count, PQ_CAPACITY); end
    do_pop(g, e);
    cyc(8);
    checks++; if (n_rep - rp0 !== 1) begin errors++; $display("FAIL full_replace: got %0d want 1", n_rep - rp0); end
    checks++; if (popped_q.size() < 1 || popped_q[0] !== mk(10)) begin
      errors++; $display("FAIL full_pop_kv: got %h want %h", (popped_q.size() > 0) ? popped_q[0] : kv_t'(0), mk(10)); end
    checks++; if (count !== CNT_W'(PQ_CAPACITY)) begin errors++; $display("FAIL full_count_after: got %0d want %0d", count, PQ_CAPACITY); end
    do_pop(g, e);
    cyc(8);
    checks++; if (popped_q.size() < 2 || popped_q[1] !== mk(4)) begin
      errors++; $display("FAIL full_inserted_min: got %h want %h", (popped_q.size() > 1) ? popped_q[1] : kv_t'(0), mk(4)); end
  endtask

  task automatic test_random();
    bit ok, g, e;
    for (int it = 0; it < 3; it++) begin
      int exp_q[$];
      int n;
      do_reset();
      sift_len = int'($urandom_range(1, 6));
      n = int'($urandom_range(3, PQ_CAPACITY));
      while (exp_q.size() < n) begin
        int k = int'($urandom_range(0, 255));
        int dup[$] = exp_q.find_index() with (item == k);
        if (dup.size() == 0) begin
          exp_q.push_back(k);
          push_kv(mk(k), ok);
          cyc(int'($urandom_range(0, 3)));
        end
      end
      wait_count(n, ok);
      checks++; if (count !== CNT_W'(n)) begin errors++; $display("FAIL rnd%0d_count: got %0d want %0d", it, count, n); end
      for (int i = 0; i < n; i++) do_pop(g, e);
      cyc(8);
      exp_q.sort();
      for (int i = 0; i < n; i++) begin
        checks++;
        if (i >= popped_q.size() || popped_q[i] !== mk(exp_q[i])) begin
          errors++;
          $display("FAIL rnd%0d_pop[%0d]: got %h want %h", it, i,
                   (i < popped_q.size()) ? popped_q[i] : kv_t'(0), mk(exp_q[i]));
        end
      end
      checks++; if (count !== '0) begin errors++; $display("FAIL rnd%0d_count_end: got %0d want 0", it, count); end
    end
  endtask

  task automatic test_reset_midop();
    bit ok, g, e;
    int e0;
    do_reset();
    sift_len = 1;
    push_kv(mk(20), ok);
    wait_count(1, ok);
    do_pop(g, e);
    sift_len = 30;
    push_kv(mk(21), ok);
    wait_enq(ok);
    cyc(3);
    push_kv(mk(22), ok);
    push_kv(mk(23), ok);
    #2 rst = 1'b0;
    #1;
    checks++; if (count !== '0) begin errors++; $display("FAIL arst_count: got %0d want 0", count); end
    checks++; if (pop_kv !== kv_t'(0)) begin errors++; $display("FAIL arst_pop_kv: got %h want 0", pop_kv); end
    checks++; if (ins_ready !== 1'b1) begin errors++; $display("FAIL arst_ins_ready: got %b want 1", ins_ready); end
    checks++; if ({pop_gnt, pop_valid, pop_err, pq_bus.enq, pq_bus.deq} !== 5'b0) begin
      errors++; $display("FAIL arst_pulses: got %b want 00000", {pop_gnt, pop_valid, pop_err, pq_bus.enq, pq_bus.deq}); end
    @(posedge clk); #1 rst = 1'b1;
    e0 = n_enq;
    cyc(15);
    checks++; if (n_enq - e0 !== 0) begin errors++; $display("FAIL arst_fifo_cleared: got %0d enq want 0", n_enq - e0); end
    checks++; if (ins_ready !== 1'b1 || count !== '0) begin
      errors++; $display("FAIL arst_after_release: got ready=%b count=%0d want 1/0", ins_ready, count); end
  endtask

  initial begin
    test_reset();
    test_insert_basic();
    test_pop_order();
    test_pop_empty();
    test_replace();
    test_burst();
    test_full();
    test_random();
    test_reset_midop();
    checks++; if (n_viol !== 0) begin errors++; $display("FAIL strobe_protocol: got %0d violations want 0", n_viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
